// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: word handshake plus serial line status of the UART transmitter
interface uart_tx_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_serial;
  logic tx_active;
  logic tx_done;
  modport master (output tx_data, tx_valid, input tx_ready, tx_serial, tx_active, tx_done);
  modport slave (input tx_data, tx_valid, output tx_ready, tx_serial, tx_active, tx_done);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter with a one-word holding register
// feeding the shift register, so frames can be sent back to back.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst_n,
  uart_tx_param_if.slave bus
);
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_param: illegal parameter value");
  end
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift, hold;
  logic hold_full, par_bit, serial, active, done;
  logic bit_end, frame_end, load, accept;
  always_comb begin
    bit_end = cnt == LAST;
    frame_end = state == STOP && bit_end && idx == LAST_S;
    load = hold_full && (state == IDLE || frame_end);
    accept = bus.tx_valid && !hold_full;
  end
  // idx counts data bits in DATA and stop bits in STOP, keeping cnt within one bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      par_bit <= 1'b0;
      serial <= 1'b1;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= frame_end;
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + CW'(1);
      if (bit_end)
        case (state)
          START: begin
            state <= DATA;
            serial <= shift[0];
          end
          DATA: if (idx == LAST_D) begin
            idx <= '0;
            state <= PARITY != 0 ? PAR : STOP;
            serial <= PARITY != 0 ? par_bit : 1'b1;
          end else begin
            idx <= idx + IW'(1);
            shift <= shift >> 1;
            serial <= shift[1];
          end
          PAR: begin
            state <= STOP;
            serial <= 1'b1;
          end
          STOP: if (idx == LAST_S) begin
            state <= IDLE;
            active <= 1'b0;
            idx <= '0;
          end else idx <= idx + IW'(1);
          default: ;
        endcase
      // a pending word overrides the IDLE return so frames abut
      if (load) begin
        state <= START;
        serial <= 1'b0;
        active <= 1'b1;
        shift <= hold;
        hold_full <= 1'b0;
        par_bit <= ^hold ^ (PARITY == 1);
        cnt <= '0;
        idx <= '0;
      end
      if (accept) begin
        hold <= bus.tx_data;
        hold_full <= 1'b1;
      end
    end
  end
  assign bus.tx_ready = !hold_full;
  assign bus.tx_serial = serial;
  assign bus.tx_active = active;
  assign bus.tx_done = done;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations driven in lockstep and compared
// every clock against a frame-level model of the expected line.
module tb_uart_tx_param;
  localparam int CPB = 4;
  localparam int NC = 4000;
  int db[4] = '{8, 8, 8, 5};
  int par[4] = '{0, 2, 1, 0};
  int sb[4] = '{1, 1, 1, 2};
  logic clk = 1'b0;
  logic rst_n;
  logic vld[4];
  logic [8:0] dat[4];
  logic ser[4], act[4], dn[4], rdy[4];
  bit e_ser[4][NC], e_act[4][NC], e_done[4][NC], e_rdy[4][NC];
  bit rec_ser[4][NC], rec_act[4][NC], rec_done[4][NC];
  int bu[4];
  bit acc[4];
  int stage[4];
  int cyc, n_chk, n_fail;
  always #5 clk = ~clk;
  uart_tx_param_if #(.DATA_BITS(8)) ifa[3] ();
  uart_tx_param_if #(.DATA_BITS(5)) if5 ();
  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int P = i == 0 ? 0 : (i == 1 ? 2 : 1);
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(P), .STOP_BITS(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ifa[i]));
    assign ifa[i].tx_valid = vld[i];
    assign ifa[i].tx_data = dat[i][7:0];
    assign ser[i] = ifa[i].tx_serial;
    assign act[i] = ifa[i].tx_active;
    assign dn[i] = ifa[i].tx_done;
    assign rdy[i] = ifa[i].tx_ready;
  end
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5));
  assign if5.tx_valid = vld[3];
  assign if5.tx_data = dat[3][4:0];
  assign ser[3] = if5.tx_serial;
  assign act[3] = if5.tx_active;
  assign dn[3] = if5.tx_done;
  assign rdy[3] = if5.tx_ready;
  task automatic chk1(string tag, int k, logic got, logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s u%0d: got %b expected %b at cycle %0d", tag, k, got, exp, cyc);
    end
  endtask
  task automatic chkn(string tag, int k, int got, int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s u%0d: got %0h expected %0h at cycle %0d", tag, k, got, exp, cyc);
    end
  endtask
  task automatic clear_from(int c0);
    for (int k = 0; k < 4; k++) begin
      bu[k] = 0;
      for (int c = c0; c < NC; c++) begin
        e_ser[k][c] = 1'b1;
        e_act[k][c] = 1'b0;
        e_done[k][c] = 1'b0;
        e_rdy[k][c] = 1'b1;
      end
    end
  endtask
  // frame starts one clock after acceptance, or right at the end of the frame ahead of it
  task automatic sched(int k, logic [8:0] d);
    logic [8:0] w;
    bit fr[16];
    int s, b;
    w = d & 9'((1 << db[k]) - 1);
    s = (cyc + 1 > bu[k]) ? cyc + 1 : bu[k];
    for (int c = cyc; c < s; c++) e_rdy[k][c] = 1'b0;
    b = 0;
    fr[b] = 1'b0;
    b = b + 1;
    for (int i = 0; i < db[k]; i++) begin
      fr[b] = w[i];
      b = b + 1;
    end
    if (par[k] != 0) begin
      fr[b] = (^w) ^ (par[k] == 1);
      b = b + 1;
    end
    for (int i = 0; i < sb[k]; i++) begin
      fr[b] = 1'b1;
      b = b + 1;
    end
    for (int i = 0; i < b; i++)
      for (int j = 0; j < CPB; j++) begin
        e_ser[k][s + i * CPB + j] = fr[i];
        e_act[k][s + i * CPB + j] = 1'b1;
      end
    e_done[k][s + b * CPB] = 1'b1;
    bu[k] = s + b * CPB;
  endtask
  task automatic step();
    for (int k = 0; k < 4; k++) acc[k] = vld[k] && e_rdy[k][cyc];
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) if (acc[k]) sched(k, dat[k]);
    #1;
    for (int k = 0; k < 4; k++) begin
      rec_ser[k][cyc] = ser[k];
      rec_act[k][cyc] = act[k];
      rec_done[k][cyc] = dn[k];
      chk1("serial", k, ser[k], e_ser[k][cyc]);
      chk1("active", k, act[k], e_act[k][cyc]);
      chk1("done", k, dn[k], e_done[k][cyc]);
      chk1("ready", k, rdy[k], e_rdy[k][cyc]);
    end
  endtask
  task automatic chk_reset(string tag);
    for (int k = 0; k < 4; k++) begin
      chk1({tag, "_serial"}, k, ser[k], 1'b1);
      chk1({tag, "_ready"}, k, rdy[k], 1'b1);
      chk1({tag, "_active"}, k, act[k], 1'b0);
      chk1({tag, "_done"}, k, dn[k], 1'b0);
    end
  endtask
  initial begin
    int t0, cnt, v;
    int len[4] = '{10, 11, 11, 8};
    int pat[4] = '{32'h34A, 32'h60E, 32'h40E, 32'hFE};
    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    clear_from(0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset("rst");
    step();
    step();
    #2 rst_n = 1'b1;
    // single frames: 0xA5 plain, 0x07 even and odd parity, 0x1F on five bits with two stops
    dat = '{9'h0A5, 9'h007, 9'h007, 9'h01F};
    for (int k = 0; k < 4; k++) vld[k] = 1'b1;
    step();
    t0 = cyc;
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    repeat (50) step();
    for (int k = 0; k < 4; k++) begin
      v = 0;
      for (int i = 0; i < len[k]; i++) v[i] = rec_ser[k][t0 + 1 + i * CPB + 2];
      chkn("frame_bits", k, v, pat[k]);
      chk1("done_at_end", k, rec_done[k][t0 + 1 + len[k] * CPB], 1'b1);
      cnt = 0;
      for (int c = t0; c <= t0 + 50; c++) cnt += int'(rec_act[k][c]);
      chkn("active_len", k, cnt, len[k] * CPB);
    end
    // two words held back to back
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b1;
      dat[k] = 9'h055;
      stage[k] = 0;
    end
    repeat (110) begin
      step();
      for (int k = 0; k < 4; k++)
        if (acc[k]) begin
          if (stage[k] == 0) dat[k] = 9'h0AA;
          else vld[k] = 1'b0;
          stage[k]++;
        end
    end
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      for (int c = t0 + 1; c <= cyc; c++) cnt += int'(rec_done[k][c]);
      chkn("b2b_done_count", k, cnt, 2);
    end
    // reset in the third data bit, with a second word waiting in holding
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b1;
      dat[k] = 9'($urandom);
    end
    step();
    t0 = cyc;
    for (int k = 0; k < 4; k++) dat[k] = 9'($urandom);
    step();
    step();
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    while (cyc < t0 + 14) step();
    #2 rst_n = 1'b0;
    #1;
    clear_from(cyc);
    chk_reset("rst_mid");
    step();
    step();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b1;
      dat[k] = 9'($urandom);
    end
    step();
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    repeat (60) step();
    // random valid toggling with data changing every clock
    repeat (1200) begin
      for (int k = 0; k < 4; k++) begin
        vld[k] = $urandom_range(0, 3) != 0;
        dat[k] = 9'($urandom);
      end
      step();
    end
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    repeat (100) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
